// File: rtl/jtframe_z80_busctl.sv
// Z80 bus / clock-enable controller: stalls cpu_cen during SDRAM ROM reads,
// replays the lost enables afterwards and arbitrates BUSRQ_n for one DMA master.
module jtframe_z80_busctl #(
  parameter int unsigned RECOVERY = 1,
  parameter int unsigned CNTW     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic cen,
  output logic cpu_cen,
  input  logic mreq_n,
  input  logic rd_n,
  input  logic rfsh_n,
  input  logic rom_cs,
  input  logic rom_ok,
  output logic rom_req,
  input  logic dma_req,
  output logic dma_gnt,
  output logic busrq_n,
  input  logic busak_n,
  output logic stall
);

  localparam logic [CNTW-1:0] CNT_MAX = '1;
  localparam bit              REC_EN  = (RECOVERY != 0);

  typedef enum logic       { RIDLE, RWAIT }      rom_st_t;
  typedef enum logic [1:0] { BIDLE, BREQ, BGNT } bus_st_t;

  rom_st_t         rom_st_q, rom_st_d;
  bus_st_t         bus_st_q, bus_st_d;
  logic            arm_q, arm_d;
  logic            served_q, served_d;
  logic            rom_req_q, rom_req_d;
  logic            busrq_n_q, busrq_n_d;
  logic            dma_gnt_q, dma_gnt_d;
  logic            cpu_cen_q, cpu_cen_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic start, hold, rec_pulse, done;

  // ROM access detection, enable gating and lost-pulse bookkeeping
  always_comb begin
    start     = rom_cs & ~mreq_n & ~rd_n & rfsh_n & ~served_q;
    hold      = ~rst & (start | (rom_st_q == RWAIT));
    rec_pulse = REC_EN & (rom_st_q == RIDLE) & ~start & ~cen
                & (cnt_q != '0) & ~cpu_cen_q;
    cpu_cen_d = rst ? cen : ((cen & ~hold) | rec_pulse);

    cnt_d = cnt_q;
    if (REC_EN) begin
      if (cen && hold && cnt_q != CNT_MAX) cnt_d = cnt_q + CNTW'(1);
      else if (rec_pulse)                  cnt_d = cnt_q - CNTW'(1);
    end
  end

  // ROM FSM: ok is only trusted once the request has been up for a full cycle
  always_comb begin
    rom_st_d = rom_st_q;
    arm_d    = 1'b0;
    done     = 1'b0;
    case (rom_st_q)
      RIDLE: if (start) rom_st_d = RWAIT;
      RWAIT: begin
        if (arm_q && rom_ok) begin
          rom_st_d = RIDLE;
          done     = 1'b1;
        end else begin
          arm_d = 1'b1;
        end
      end
      default: rom_st_d = RIDLE;
    endcase
    served_d  = done ? 1'b1 : (mreq_n ? 1'b0 : served_q);
    rom_req_d = (rom_st_d == RWAIT);
  end

  // Bus FSM: a ROM access in flight or starting takes priority over a new DMA request
  always_comb begin
    bus_st_d = bus_st_q;
    case (bus_st_q)
      BIDLE: if (dma_req && rom_st_q == RIDLE && !start) bus_st_d = BREQ;
      BREQ: begin
        if (!dma_req)      bus_st_d = BIDLE;
        else if (!busak_n) bus_st_d = BGNT;
      end
      BGNT:    if (!dma_req) bus_st_d = BIDLE;
      default: bus_st_d = BIDLE;
    endcase
    busrq_n_d = (bus_st_d == BIDLE);
    dma_gnt_d = (bus_st_d == BGNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_st_q  <= RIDLE;
      bus_st_q  <= BIDLE;
      arm_q     <= 1'b0;
      served_q  <= 1'b0;
      rom_req_q <= 1'b0;
      busrq_n_q <= 1'b1;
      dma_gnt_q <= 1'b0;
      cpu_cen_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      rom_st_q  <= rom_st_d;
      bus_st_q  <= bus_st_d;
      arm_q     <= arm_d;
      served_q  <= served_d;
      rom_req_q <= rom_req_d;
      busrq_n_q <= busrq_n_d;
      dma_gnt_q <= dma_gnt_d;
      cpu_cen_q <= cpu_cen_d;
      cnt_q     <= cnt_d;
    end
  end

  assign cpu_cen = cpu_cen_d;
  assign stall   = hold;
  assign rom_req = rom_req_q;
  assign busrq_n = busrq_n_q;
  assign dma_gnt = dma_gnt_q;

endmodule

// File: tb/tb_jtframe_z80_busctl.sv
// Directed bench for jtframe_z80_busctl; a RECOVERY=1 and a RECOVERY=0 copy share the stimulus.
module tb_jtframe_z80_busctl;

  logic clk = 1'b0;
  logic rst, cen, mreq_n, rd_n, rfsh_n, rom_cs, rom_ok, dma_req, busak_n;
  logic cpu_cen1, rom_req1, dma_gnt1, busrq_n1, stall1;
  logic cpu_cen0, rom_req0, dma_gnt0, busrq_n0, stall0;

  logic s_cen, s_mreq_n, s_rd_n, s_rom_cs, s_rom_ok, s_dma_req, s_busak_n;
  bit   auto_cen;
  int   cyc, total, bad, n1, n0, adj;
  logic prev1, prev0;

  always #5 clk = ~clk;

  jtframe_z80_busctl #(.RECOVERY(1), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .cen(cen), .cpu_cen(cpu_cen1),
    .mreq_n(mreq_n), .rd_n(rd_n), .rfsh_n(rfsh_n),
    .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_req(rom_req1),
    .dma_req(dma_req), .dma_gnt(dma_gnt1), .busrq_n(busrq_n1),
    .busak_n(busak_n), .stall(stall1)
  );

  jtframe_z80_busctl #(.RECOVERY(0), .CNTW(4)) dut0 (
    .clk(clk), .rst(rst), .cen(cen), .cpu_cen(cpu_cen0),
    .mreq_n(mreq_n), .rd_n(rd_n), .rfsh_n(rfsh_n),
    .rom_cs(rom_cs), .rom_ok(rom_ok), .rom_req(rom_req0),
    .dma_req(dma_req), .dma_gnt(dma_gnt0), .busrq_n(busrq_n0),
    .busak_n(busak_n), .stall(stall0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply staged inputs just after the edge, sample mid-cycle
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    mreq_n  = s_mreq_n;
    rd_n    = s_rd_n;
    rom_cs  = s_rom_cs;
    rom_ok  = s_rom_ok;
    dma_req = s_dma_req;
    busak_n = s_busak_n;
    cen     = auto_cen ? (cyc % 4 == 0) : s_cen;
    #4;
    n1 += int'(cpu_cen1);
    n0 += int'(cpu_cen0);
    if (cpu_cen1 && prev1) adj++;
    if (cpu_cen0 && prev0) adj++;
    prev1 = cpu_cen1;
    prev0 = cpu_cen0;
  endtask

  task automatic access(input logic on);
    s_rom_cs = on;
    s_mreq_n = ~on;
    s_rd_n   = ~on;
  endtask

  initial begin
    total = 0; bad = 0; n1 = 0; n0 = 0; adj = 0; prev1 = 0; prev0 = 0; cyc = 0;
    auto_cen = 0;
    s_cen = 0; s_rom_ok = 0; s_dma_req = 0; s_busak_n = 1;
    access(1'b0);
    rst = 1; cen = 0; mreq_n = 1; rd_n = 1; rfsh_n = 1; rom_cs = 0;
    rom_ok = 0; dma_req = 0; busak_n = 1;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_rom_req", rom_req1, 1'b0);
    chk("rst_busrq_n", busrq_n1, 1'b1);
    chk("rst_dma_gnt", dma_gnt1, 1'b0);
    chk("rst_stall",   stall1,   1'b0);
    chk("rst_cnt",     dut.cnt_q, 4'd0);
    cen = 1; #1;
    chk("rst_cen_pass_hi", cpu_cen1, 1'b1);
    cen = 0; #1;
    chk("rst_cen_pass_lo", cpu_cen1, 1'b0);
    rst = 0;

    // cen every 4th cycle, ROM read at cycle 2, rom_ok 10 cycles after rom_req
    cyc = -1; auto_cen = 1; n1 = 0; n0 = 0;
    for (int k = 0; k < 64; k++) begin
      if (k == 2)  access(1'b1);
      if (k == 13) s_rom_ok = 1;
      if (k == 14) s_rom_ok = 0;
      if (k == 15) access(1'b0);
      cycle();
      if (k == 2) begin
        chk("t1_req_not_yet", rom_req1, 1'b0);
        chk("t1_stall_on_start", stall1, 1'b1);
      end
      if (k == 3)  chk("t1_req_after_start", rom_req1, 1'b1);
      if (k == 12) chk("t1_cen_blocked", cpu_cen1, 1'b0);
      if (k == 13) begin
        chk("t1_cnt_lost", dut.cnt_q, 4'd3);
        chk("t1_no_cen_in_wait", n1, 1);
        chk("t3_cnt_zero", dut0.cnt_q, 4'd0);
      end
      if (k == 14) begin
        chk("t1_req_drop", rom_req1, 1'b0);
        chk("t1_stall_off", stall1, 1'b0);
        chk("t2_rec_pulse", cpu_cen1, 1'b1);
        chk("t3_no_rec_pulse", cpu_cen0, 1'b0);
      end
      if (k == 15) begin
        chk("t2_cnt_dec", dut.cnt_q, 4'd2);
        chk("t2_gap_after_rec", cpu_cen1, 1'b0);
      end
      if (k == 23) chk("t2_cnt_drained", dut.cnt_q, 4'd0);
      if (k == 63) begin
        chk("t2_pulses_64", n1, 16);
        chk("t3_pulses_64", n0, 13);
        chk("t3_cnt_still_zero", dut0.cnt_q, 4'd0);
      end
    end
    auto_cen = 0; s_cen = 0;

    // Stale rom_ok held high before the request is ignored in the first wait cycle
    s_rom_ok = 1;
    cycle(); cycle();
    access(1'b1);
    cycle();
    chk("t4_stall_start", stall1, 1'b1);
    cycle();
    chk("t4_req_up", rom_req1, 1'b1);
    s_rom_ok = 0;
    cycle();
    chk("t4_stale_ignored", rom_req1, 1'b1);
    cycle();
    s_rom_ok = 1;
    cycle();
    chk("t4_req_still_up", rom_req1, 1'b1);
    s_rom_ok = 0;
    cycle();
    chk("t4_req_done", rom_req1, 1'b0);
    access(1'b0);
    cycle(); cycle();

    // DMA request together with a ROM start: ROM first, then bus grant and release
    s_dma_req = 1; access(1'b1);
    cycle();
    chk("t5_busrq_hold0", busrq_n1, 1'b1);
    cycle();
    chk("t5_busrq_hold1", busrq_n1, 1'b1);
    s_rom_ok = 1;
    cycle();
    s_rom_ok = 0;
    cycle();
    chk("t5_rom_done", rom_req1, 1'b0);
    chk("t5_busrq_late", busrq_n1, 1'b1);
    access(1'b0);
    cycle();
    chk("t5_busrq_low", busrq_n1, 1'b0);
    chk("t5_gnt_not_yet", dma_gnt1, 1'b0);
    s_busak_n = 0;
    cycle();
    chk("t5_gnt_wait", dma_gnt1, 1'b0);
    cycle();
    chk("t5_gnt_on", dma_gnt1, 1'b1);
    s_dma_req = 0;
    cycle();
    chk("t5_gnt_held", dma_gnt1, 1'b1);
    s_busak_n = 1;
    cycle();
    chk("t5_gnt_off", dma_gnt1, 1'b0);
    chk("t5_busrq_rel", busrq_n1, 1'b1);

    // Request withdrawn before the grant
    s_dma_req = 1;
    cycle(); cycle();
    chk("t5b_busrq_low", busrq_n1, 1'b0);
    s_dma_req = 0;
    cycle(); cycle();
    chk("t5b_busrq_rel", busrq_n1, 1'b1);
    chk("t5b_no_gnt", dma_gnt1, 1'b0);

    // Reset during RWAIT with five lost pulses
    s_cen = 1; access(1'b1);
    repeat (5) cycle();
    s_cen = 0;
    cycle();
    chk("t6_cnt5", dut.cnt_q, 4'd5);
    chk("t6_req_up", rom_req1, 1'b1);
    #1 rst = 1;
    #1;
    chk("t6_req_async", rom_req1, 1'b0);
    chk("t6_cnt_async", dut.cnt_q, 4'd0);
    chk("t6_stall_rst", stall1, 1'b0);
    access(1'b0);
    mreq_n = 1; rd_n = 1; rom_cs = 0;
    cycle();
    rst = 0;

    // Reset during BGNT
    s_dma_req = 1;
    cycle(); cycle();
    s_busak_n = 0;
    cycle(); cycle();
    chk("t6_gnt_on", dma_gnt1, 1'b1);
    #1 rst = 1;
    #1;
    chk("t6_gnt_async", dma_gnt1, 1'b0);
    chk("t6_busrq_async", busrq_n1, 1'b1);
    s_dma_req = 0; s_busak_n = 1; dma_req = 0; busak_n = 1;
    cycle();
    rst = 0;

    // Normal ROM access after reset release
    access(1'b1);
    cycle();
    chk("t6_post_stall", stall1, 1'b1);
    cycle();
    chk("t6_post_req", rom_req1, 1'b1);
    cycle();
    s_rom_ok = 1;
    cycle();
    s_rom_ok = 0;
    cycle();
    chk("t6_post_done", rom_req1, 1'b0);
    access(1'b0);
    cycle(); cycle();

    chk("cen_never_adjacent", adj, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
